// File: rtl/mc_pulse_burst.sv
// Pulse-burst generator: on an accepted trigger, emits io_pulseCount pulses with captured high/low times.
// Define MC_PULSE_BURST_RETRIG_EN to let a trigger during a burst restart it.
module mc_pulse_burst #(
  parameter int unsigned CNT_W = 24,
  parameter int unsigned NUM_W = 16
) (
  input  logic             io_clk,
  input  logic             io_rst,
  input  logic             io_enable,
  input  logic             io_trigger,
  input  logic [CNT_W-1:0] io_highTime,
  input  logic [CNT_W-1:0] io_lowTime,
  input  logic [NUM_W-1:0] io_pulseCount,
  output logic             io_pulse,
  output logic             io_busy,
  output logic             io_done,
  output logic [NUM_W-1:0] io_pulseIdx
);

`ifdef MC_PULSE_BURST_RETRIG_EN
  localparam bit RETRIG_EN = 1'b1;
`else
  localparam bit RETRIG_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] sh_high_q, sh_high_d;
  logic [CNT_W-1:0] sh_low_q, sh_low_d;
  logic [NUM_W-1:0] sh_num_q, sh_num_d;
  logic [NUM_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;

  logic             trig_ok;
  logic [CNT_W-1:0] high_min;
  logic [CNT_W-1:0] low_min;

  assign trig_ok  = io_enable & io_trigger;
  assign high_min = (io_highTime == '0) ? CNT_W'(1) : io_highTime;
  assign low_min  = (io_lowTime  == '0) ? CNT_W'(1) : io_lowTime;

  always_ff @(posedge io_clk or posedge io_rst) begin
    if (io_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sh_high_q <= '0;
      sh_low_q  <= '0;
      sh_num_q  <= '0;
      idx_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_high_q <= sh_high_d;
      sh_low_q  <= sh_low_d;
      sh_num_q  <= sh_num_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_high_d = sh_high_q;
    sh_low_d  = sh_low_q;
    sh_num_d  = sh_num_q;
    idx_d     = idx_q;
    done_d    = 1'b0;

    // Abort takes priority, then (re)start; only then the normal phase sequencing.
    if (state_q != IDLE && !io_enable) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (trig_ok && (state_q == IDLE || RETRIG_EN)) begin
      cnt_d = '0;
      if (io_pulseCount != '0) begin
        sh_high_d = high_min;
        sh_low_d  = low_min;
        sh_num_d  = io_pulseCount;
        idx_d     = '0;
        state_d   = HIGH;
      end else begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end else begin
      case (state_q)
        HIGH: begin
          if (cnt_q == sh_high_q - CNT_W'(1)) begin
            cnt_d = '0;
            if (idx_q == sh_num_q - NUM_W'(1)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = LOW;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        LOW: begin
          if (cnt_q == sh_low_q - CNT_W'(1)) begin
            cnt_d   = '0;
            idx_d   = idx_q + NUM_W'(1);
            state_d = HIGH;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign io_pulse    = (state_q == HIGH);
  assign io_busy     = (state_q != IDLE);
  assign io_done     = done_q;
  assign io_pulseIdx = idx_q;

endmodule

// File: tb/tb_mc_pulse_burst.sv
// Directed self-checking bench for mc_pulse_burst; cycle T+k is observed at the k-th falling edge after the trigger.
module tb_mc_pulse_burst;

  localparam int unsigned CNT_W = 24;
  localparam int unsigned NUM_W = 16;

  logic             io_clk;
  logic             io_rst;
  logic             io_enable;
  logic             io_trigger;
  logic [CNT_W-1:0] io_highTime;
  logic [CNT_W-1:0] io_lowTime;
  logic [NUM_W-1:0] io_pulseCount;
  logic             io_pulse;
  logic             io_busy;
  logic             io_done;
  logic [NUM_W-1:0] io_pulseIdx;

  int n_cmp = 0;
  int n_bad = 0;

  mc_pulse_burst #(.CNT_W(CNT_W), .NUM_W(NUM_W)) dut (
    .io_clk       (io_clk),
    .io_rst       (io_rst),
    .io_enable    (io_enable),
    .io_trigger   (io_trigger),
    .io_highTime  (io_highTime),
    .io_lowTime   (io_lowTime),
    .io_pulseCount(io_pulseCount),
    .io_pulse     (io_pulse),
    .io_busy      (io_busy),
    .io_done      (io_done),
    .io_pulseIdx  (io_pulseIdx)
  );

  initial io_clk = 1'b0;
  always #5 io_clk = ~io_clk;

  task automatic start_burst(input int h, input int l, input int n);
    @(negedge io_clk);
    io_highTime   = CNT_W'(h);
    io_lowTime    = CNT_W'(l);
    io_pulseCount = NUM_W'(n);
    io_trigger    = 1'b1;
  endtask

  task automatic test_reset;
    logic [2:0] got;
    io_rst = 1'b1; io_enable = 1'b0; io_trigger = 1'b0;
    io_highTime = '0; io_lowTime = '0; io_pulseCount = '0;
    repeat (2) @(negedge io_clk);
    got = {io_pulse, io_busy, io_done};
    n_cmp++;
    if (got !== 3'b000) begin n_bad++; $display("FAIL reset_outs got=%b exp=000", got); end
    n_cmp++;
    if (io_pulseIdx !== '0) begin n_bad++; $display("FAIL reset_idx got=%0d exp=0", io_pulseIdx); end
    io_rst = 1'b0; io_enable = 1'b1;
    @(negedge io_clk);
    got = {io_pulse, io_busy, io_done};
    n_cmp++;
    if (got !== 3'b000) begin n_bad++; $display("FAIL post_reset_idle got=%b exp=000", got); end
  endtask

  task automatic test_basic;
    logic [2:0] got, exp;
    start_burst(3, 2, 2);
    for (int k = 1; k <= 10; k++) begin
      @(negedge io_clk);
      if (k == 1) io_trigger = 1'b0;
      exp[2] = (k >= 1 && k <= 3) || (k >= 6 && k <= 8);
      exp[1] = (k >= 1 && k <= 8);
      exp[0] = (k == 9);
      got = {io_pulse, io_busy, io_done};
      n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL basic k=%0d pulse/busy/done got=%b exp=%b", k, got, exp); end
    end
    n_cmp++;
    if (io_pulseIdx !== NUM_W'(1)) begin n_bad++; $display("FAIL basic_idx got=%0d exp=1", io_pulseIdx); end
  endtask

  task automatic test_min_time;
    logic [2:0] got, exp;
    start_burst(0, 0, 3);
    for (int k = 1; k <= 7; k++) begin
      @(negedge io_clk);
      if (k == 1) io_trigger = 1'b0;
      exp[2] = (k == 1) || (k == 3) || (k == 5);
      exp[1] = (k <= 5);
      exp[0] = (k == 6);
      got = {io_pulse, io_busy, io_done};
      n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL min_time k=%0d pulse/busy/done got=%b exp=%b", k, got, exp); end
    end
    n_cmp++;
    if (io_pulseIdx !== NUM_W'(2)) begin n_bad++; $display("FAIL min_time_idx got=%0d exp=2", io_pulseIdx); end
  endtask

  task automatic test_zero_count;
    logic [2:0] got, exp;
    start_burst(3, 3, 0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge io_clk);
      if (k == 1) io_trigger = 1'b0;
      exp = (k == 1) ? 3'b001 : 3'b000;
      got = {io_pulse, io_busy, io_done};
      n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL zero_count k=%0d pulse/busy/done got=%b exp=%b", k, got, exp); end
    end
    n_cmp++;
    if (io_pulseIdx !== NUM_W'(2)) begin n_bad++; $display("FAIL zero_count_idx_hold got=%0d exp=2", io_pulseIdx); end
  endtask

  task automatic test_abort;
    logic [2:0] got, exp;
    // Drop enable during the first gap (T+8): pulse index still 0.
    start_burst(5, 5, 4);
    for (int k = 1; k <= 14; k++) begin
      @(negedge io_clk);
      if (k == 1) io_trigger = 1'b0;
      exp[2] = (k <= 5);
      exp[1] = (k <= 8);
      exp[0] = 1'b0;
      got = {io_pulse, io_busy, io_done};
      n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL abort_a k=%0d pulse/busy/done got=%b exp=%b", k, got, exp); end
      if (k == 8) io_enable = 1'b0;
    end
    n_cmp++;
    if (io_pulseIdx !== NUM_W'(0)) begin n_bad++; $display("FAIL abort_a_idx got=%0d exp=0", io_pulseIdx); end
    io_enable = 1'b1;
    // Drop enable in the second pulse (T+13): pulse index 1 held.
    start_burst(5, 5, 4);
    for (int k = 1; k <= 18; k++) begin
      @(negedge io_clk);
      if (k == 1) io_trigger = 1'b0;
      exp[2] = (k <= 5) || (k >= 11 && k <= 13);
      exp[1] = (k <= 13);
      exp[0] = 1'b0;
      got = {io_pulse, io_busy, io_done};
      n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL abort_b k=%0d pulse/busy/done got=%b exp=%b", k, got, exp); end
      if (k == 13) io_enable = 1'b0;
    end
    n_cmp++;
    if (io_pulseIdx !== NUM_W'(1)) begin n_bad++; $display("FAIL abort_b_idx got=%0d exp=1", io_pulseIdx); end
    io_enable = 1'b1;
  endtask

  task automatic test_retrig;
    logic [2:0] got, exp;
    start_burst(4, 4, 2);
    for (int k = 1; k <= 27; k++) begin
      @(negedge io_clk);
      if (k == 1) io_trigger = 1'b0;
`ifdef MC_PULSE_BURST_RETRIG_EN
      exp[2] = (k <= 12) || (k >= 17 && k <= 25);
      exp[1] = (k <= 25);
      exp[0] = (k == 26);
`else
      exp[2] = (k <= 4) || (k >= 9 && k <= 12);
      exp[1] = (k <= 12);
      exp[0] = (k == 13);
`endif
      got = {io_pulse, io_busy, io_done};
      n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL retrig k=%0d pulse/busy/done got=%b exp=%b", k, got, exp); end
      if (k == 2) io_highTime = CNT_W'(9);
      if (k == 3) io_trigger = 1'b1;
      if (k == 4) io_trigger = 1'b0;
    end
    n_cmp++;
    if (io_pulseIdx !== NUM_W'(1)) begin n_bad++; $display("FAIL retrig_idx got=%0d exp=1", io_pulseIdx); end
  endtask

  task automatic test_back_to_back;
    logic [2:0] got, exp;
    start_burst(1, 1, 1);
    for (int k = 1; k <= 7; k++) begin
      @(negedge io_clk);
      exp = (k == 7) ? 3'b000 : ((k % 2 == 1) ? 3'b110 : 3'b001);
      got = {io_pulse, io_busy, io_done};
      n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL back_to_back k=%0d pulse/busy/done got=%b exp=%b", k, got, exp); end
      if (k == 6) io_trigger = 1'b0;
    end
  endtask

  task automatic test_reset_mid;
    logic [2:0] got, exp;
    start_burst(4, 4, 3);
    @(negedge io_clk);
    io_trigger = 1'b0;
    @(negedge io_clk);
    #1 io_rst = 1'b1;
    #1;
    got = {io_pulse, io_busy, io_done};
    n_cmp++;
    if (got !== 3'b000) begin n_bad++; $display("FAIL reset_mid_outs got=%b exp=000", got); end
    n_cmp++;
    if (io_pulseIdx !== '0) begin n_bad++; $display("FAIL reset_mid_idx got=%0d exp=0", io_pulseIdx); end
    @(negedge io_clk);
    io_rst = 1'b0;
    start_burst(2, 1, 2);
    for (int k = 1; k <= 6; k++) begin
      @(negedge io_clk);
      if (k == 1) io_trigger = 1'b0;
      exp[2] = (k <= 2) || (k == 4 || k == 5);
      exp[1] = (k <= 5);
      exp[0] = (k == 6);
      got = {io_pulse, io_busy, io_done};
      n_cmp++;
      if (got !== exp) begin n_bad++; $display("FAIL reset_mid_clean k=%0d pulse/busy/done got=%b exp=%b", k, got, exp); end
      if (k == 1) begin
        n_cmp++;
        if (io_pulseIdx !== NUM_W'(0)) begin n_bad++; $display("FAIL reset_mid_clean_idx got=%0d exp=0", io_pulseIdx); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_min_time();
    test_zero_count();
    test_abort();
    test_retrig();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge io_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
